// File: rtl/key_conditioner.sv
// Debounces three raw active-low keys and turns accepted presses into one-cycle strobes.
// Enter wins over a simultaneous exit, which is deferred by one cycle; a held clear key suppresses both.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CTR_W           = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] pushkey,
    output logic       enter_pulse,
    output logic       exit_pulse,
    output logic       clear_pulse,
    output logic [2:0] key_state
);

    localparam logic [CTR_W-1:0] CNT_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       sampled;
    logic [2:0]       stable_q, stable_d;
    logic [2:0]       stable_prev_q;
    logic [2:0]       press;
    logic [CTR_W-1:0] cnt_q [3];
    logic [CTR_W-1:0] cnt_d [3];
    logic             pend_q, pend_d;
    logic             enter_q, enter_d;
    logic             exit_q, exit_d;
    logic             clear_q, clear_d;

    assign sampled = ~sync2_q;
    assign press   = stable_q & ~stable_prev_q;

    always_comb begin
        stable_d = stable_q;
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = '0;
            if (sampled[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    stable_d[k] = sampled[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CTR_W'(1);
                end
            end
        end
    end

    // A deferred exit is only lost when clear becomes active before it is emitted.
    always_comb begin
        clear_d = press[2];
        enter_d = 1'b0;
        exit_d  = 1'b0;
        pend_d  = pend_q;
        if (stable_q[2]) begin
            pend_d = 1'b0;
        end else if (press[0]) begin
            enter_d = 1'b1;
            pend_d  = pend_q | press[1];
        end else if (press[1] || pend_q) begin
            exit_d = 1'b1;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 3'b111;
            sync2_q       <= 3'b111;
            stable_q      <= 3'b000;
            stable_prev_q <= 3'b000;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
            pend_q        <= 1'b0;
            enter_q       <= 1'b0;
            exit_q        <= 1'b0;
            clear_q       <= 1'b0;
        end else begin
            sync1_q       <= pushkey;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
            pend_q        <= pend_d;
            enter_q       <= enter_d;
            exit_q        <= exit_d;
            clear_q       <= clear_d;
        end
    end

    assign enter_pulse = enter_q;
    assign exit_pulse  = exit_q;
    assign clear_pulse = clear_q;
    assign key_state   = stable_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with a small debounce window.
module tb_key_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] pushkey;
    logic       enter_pulse, exit_pulse, clear_pulse;
    logic [2:0] key_state;

    int checks   = 0;
    int failures = 0;

    key_conditioner #(.DEBOUNCE_CYCLES(D), .CTR_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pushkey    (pushkey),
        .enter_pulse(enter_pulse),
        .exit_pulse (exit_pulse),
        .clear_pulse(clear_pulse),
        .key_state  (key_state)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last D synchronised samples all disagree with it.
    logic [2:0] raw_hist [$];
    logic [2:0] seen_hist [$];
    logic [2:0] m_stable, m_rose;
    logic       m_pend, m_ent, m_ext, m_clr, m_rst;

    task automatic model_reset();
        raw_hist  = {3'b000, 3'b000};
        seen_hist = {};
        m_stable  = 3'b000;
        m_rose    = 3'b000;
        m_pend    = 1'b0;
        m_ent     = 1'b0;
        m_ext     = 1'b0;
        m_clr     = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] pk);
        logic [2:0] seen;
        bit         all_diff;
        if (m_rst) return;
        m_clr = m_rose[2];
        m_ent = 1'b0;
        m_ext = 1'b0;
        if (m_stable[2]) begin
            m_pend = 1'b0;
        end else if (m_rose[0]) begin
            m_ent  = 1'b1;
            m_pend = m_pend | m_rose[1];
        end else begin
            m_ext  = m_rose[1] | m_pend;
            m_pend = 1'b0;
        end
        raw_hist.push_back(~pk);
        seen = raw_hist[raw_hist.size() - 3];
        if (raw_hist.size() > 3) void'(raw_hist.pop_front());
        seen_hist.push_back(seen);
        if (seen_hist.size() > D) void'(seen_hist.pop_front());
        for (int k = 0; k < 3; k++) begin
            m_rose[k] = 1'b0;
            all_diff  = (seen_hist.size() == D);
            foreach (seen_hist[i]) if (seen_hist[i][k] == m_stable[k]) all_diff = 0;
            if (all_diff) begin
                m_stable[k] = ~m_stable[k];
                m_rose[k]   = m_stable[k];
            end
        end
    endtask

    task automatic step(input logic [2:0] pk);
        pushkey = pk;
        @(posedge clk);
        model_edge(pk);
        @(negedge clk);
    endtask

    task automatic assert_reset(input int cycles);
        reset_n = 1'b0;
        m_rst   = 1'b1;
        model_reset();
        repeat (cycles) step(3'b111);
        reset_n = 1'b1;
        m_rst   = 1'b0;
    endtask

    task automatic test_reset();
        pushkey = 3'b000;
        reset_n = 1'b0;
        m_rst   = 1'b1;
        model_reset();
        #1;
        repeat (3) @(negedge clk);
        checks++;
        if ({key_state, clear_pulse, exit_pulse, enter_pulse} !== 6'b0) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=000000", {key_state, clear_pulse, exit_pulse, enter_pulse});
        end
        reset_n = 1'b1;
        m_rst   = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(3'b111);
            checks++;
            if ({key_state, clear_pulse, exit_pulse, enter_pulse} !== {m_stable, m_clr, m_ext, m_ent}) begin
                failures++;
                $display("FAIL reset_idle e=%0d got=%b exp=%b", e,
                         {key_state, clear_pulse, exit_pulse, enter_pulse}, {m_stable, m_clr, m_ext, m_ent});
            end
        end
    endtask

    task automatic test_enter_basic();
        int ks_edge = -1, p_edge = -1, p_n = 0;
        for (int e = 1; e <= 20; e++) begin
            step(e <= 12 ? 3'b110 : 3'b111);
            checks++;
            if ({key_state, clear_pulse, exit_pulse, enter_pulse} !== {m_stable, m_clr, m_ext, m_ent}) begin
                failures++;
                $display("FAIL enter_model e=%0d got=%b exp=%b", e,
                         {key_state, clear_pulse, exit_pulse, enter_pulse}, {m_stable, m_clr, m_ext, m_ent});
            end
            if (key_state[0] && ks_edge < 0) ks_edge = e;
            if (enter_pulse) begin p_n++; p_edge = e; end
        end
        checks++;
        if (ks_edge !== 6) begin failures++; $display("FAIL enter_ks_edge got=%0d exp=6", ks_edge); end
        checks++;
        if (p_n !== 1 || p_edge !== 7) begin
            failures++;
            $display("FAIL enter_pulse count=%0d edge=%0d exp count=1 edge=7", p_n, p_edge);
        end
    endtask

    task automatic test_exit_bounce();
        logic [2:0] pk;
        int p_edge = -1, p_n = 0;
        for (int e = 1; e <= 24; e++) begin
            pk = (e == 4 || e > 16) ? 3'b111 : 3'b101;
            step(pk);
            checks++;
            if ({key_state, clear_pulse, exit_pulse, enter_pulse} !== {m_stable, m_clr, m_ext, m_ent}) begin
                failures++;
                $display("FAIL bounce_model e=%0d got=%b exp=%b", e,
                         {key_state, clear_pulse, exit_pulse, enter_pulse}, {m_stable, m_clr, m_ext, m_ent});
            end
            if (exit_pulse) begin
                p_n++;
                if (p_edge < 0) p_edge = e;
            end
        end
        checks++;
        if (p_n !== 1 || p_edge !== 11) begin
            failures++;
            $display("FAIL bounce_exit count=%0d edge=%0d exp count=1 edge=11", p_n, p_edge);
        end
    endtask

    task automatic test_simultaneous();
        int en_edge = -1, ex_edge = -1, en_n = 0, ex_n = 0, overlap = 0;
        for (int e = 1; e <= 20; e++) begin
            step(e <= 12 ? 3'b100 : 3'b111);
            checks++;
            if ({key_state, clear_pulse, exit_pulse, enter_pulse} !== {m_stable, m_clr, m_ext, m_ent}) begin
                failures++;
                $display("FAIL simul_model e=%0d got=%b exp=%b", e,
                         {key_state, clear_pulse, exit_pulse, enter_pulse}, {m_stable, m_clr, m_ext, m_ent});
            end
            if (enter_pulse) begin en_n++; en_edge = e; end
            if (exit_pulse) begin ex_n++; ex_edge = e; end
            if (enter_pulse && exit_pulse) overlap++;
        end
        checks++;
        if (en_n !== 1 || en_edge !== 7 || ex_n !== 1 || ex_edge !== 8 || overlap !== 0) begin
            failures++;
            $display("FAIL simul_order en=%0d@%0d ex=%0d@%0d ovl=%0d exp en=1@7 ex=1@8 ovl=0",
                     en_n, en_edge, ex_n, ex_edge, overlap);
        end
    endtask

    task automatic test_clear_block();
        logic [2:0] pk;
        int clr_n = 0, en_n = 0;
        for (int e = 1; e <= 38; e++) begin
            if (e <= 8)       pk = 3'b011;
            else if (e <= 18) pk = 3'b010;
            else if (e <= 30) pk = 3'b011;
            else              pk = 3'b111;
            step(pk);
            checks++;
            if ({key_state, clear_pulse, exit_pulse, enter_pulse} !== {m_stable, m_clr, m_ext, m_ent}) begin
                failures++;
                $display("FAIL clear_model e=%0d got=%b exp=%b", e,
                         {key_state, clear_pulse, exit_pulse, enter_pulse}, {m_stable, m_clr, m_ext, m_ent});
            end
            if (clear_pulse) clr_n++;
            if (enter_pulse) en_n++;
        end
        checks++;
        if (clr_n !== 1 || en_n !== 0) begin
            failures++;
            $display("FAIL clear_block clr=%0d enter=%0d exp clr=1 enter=0", clr_n, en_n);
        end
    endtask

    task automatic test_reset_mid();
        int en_n = 0, nonzero = 0;
        for (int e = 1; e <= 4; e++) step(3'b110);
        assert_reset(3);
        for (int e = 1; e <= 14; e++) begin
            step(3'b111);
            checks++;
            if ({key_state, clear_pulse, exit_pulse, enter_pulse} !== {m_stable, m_clr, m_ext, m_ent}) begin
                failures++;
                $display("FAIL rstmid_model e=%0d got=%b exp=%b", e,
                         {key_state, clear_pulse, exit_pulse, enter_pulse}, {m_stable, m_clr, m_ext, m_ent});
            end
            if (enter_pulse) en_n++;
            if ({key_state, clear_pulse, exit_pulse, enter_pulse} != 6'b0) nonzero++;
        end
        checks++;
        if (en_n !== 0 || nonzero !== 0) begin
            failures++;
            $display("FAIL rstmid_quiet enter=%0d nonzero=%0d exp 0 0", en_n, nonzero);
        end
    endtask

    task automatic test_long_hold();
        int en_n = 0, drop = -1;
        for (int e = 1; e <= 100; e++) begin
            step(3'b110);
            if (enter_pulse) en_n++;
        end
        for (int e = 1; e <= 12; e++) begin
            step(3'b111);
            checks++;
            if ({key_state, clear_pulse, exit_pulse, enter_pulse} !== {m_stable, m_clr, m_ext, m_ent}) begin
                failures++;
                $display("FAIL hold_model e=%0d got=%b exp=%b", e,
                         {key_state, clear_pulse, exit_pulse, enter_pulse}, {m_stable, m_clr, m_ext, m_ent});
            end
            if (enter_pulse) en_n++;
            if (!key_state[0] && drop < 0) drop = e;
        end
        checks++;
        if (en_n !== 1 || drop !== 6) begin
            failures++;
            $display("FAIL hold_release enter=%0d drop=%0d exp enter=1 drop=6", en_n, drop);
        end
    endtask

    task automatic test_random();
        logic [2:0] pk = 3'b111;
        int overlap = 0;
        for (int e = 1; e <= 3000; e++) begin
            if ($urandom_range(7) == 0) pk[$urandom_range(2)] ^= 1'b1;
            if ($urandom_range(999) == 0) assert_reset($urandom_range(1, 3));
            step(pk);
            checks++;
            if ({key_state, clear_pulse, exit_pulse, enter_pulse} !== {m_stable, m_clr, m_ext, m_ent}) begin
                failures++;
                $display("FAIL random_model e=%0d pk=%b got=%b exp=%b", e, pk,
                         {key_state, clear_pulse, exit_pulse, enter_pulse}, {m_stable, m_clr, m_ext, m_ent});
            end
            if (enter_pulse && exit_pulse) overlap++;
        end
        checks++;
        if (overlap !== 0) begin
            failures++;
            $display("FAIL random_overlap got=%0d exp=0", overlap);
        end
    endtask

    initial begin
        m_rst = 1'b1;
        test_reset();
        test_enter_basic();
        test_exit_bounce();
        test_simultaneous();
        test_clear_block();
        test_reset_mid();
        test_long_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning cycles a raw key level must persist before acceptance (10 ms at 50 MHz); legal range 2 to 2^CTR_W-1.
REQ-002 SHALL have parameter CTR_W, default 20, meaning debounce counter width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pushkey  input  3  raw active-low keys, asynchronous to clk: [0] enter, [1] exit, [2] clear.
REQ-006 SHALL have port enter_pulse  output  1  one-cycle registered strobe per accepted enter press.
REQ-007 SHALL have port exit_pulse  output  1  one-cycle registered strobe per accepted exit press.
REQ-008 SHALL have port clear_pulse  output  1  one-cycle registered strobe per accepted clear press.
REQ-009 SHALL have port key_state  output  3  debounced key levels, active-high pressed, bit order as pushkey.

Function
REQ-010 SHALL pass each pushkey bit through a 2-flop synchronizer, then invert it to a pressed-high sampled level.
REQ-011 SHALL keep, per key, a stable level (driving key_state) and a CTR_W-bit counter.
REQ-012 SHALL clear a key's counter on any edge where the sampled level equals its stable level.
REQ-013 SHALL increment the counter on each edge where sampled differs from stable and counter < DEBOUNCE_CYCLES-1.
REQ-014 SHALL, on an edge where sampled differs from stable and counter == DEBOUNCE_CYCLES-1, load stable with sampled and clear the counter.
REQ-015 SHALL, for a clean level change first sampled at edge 1, update key_state at edge DEBOUNCE_CYCLES+2.
REQ-016 SHALL detect a press event on a stable 0->1 transition; release (1->0) generates no event.
REQ-017 SHALL assert the matching pulse one edge after the press event (edge DEBOUNCE_CYCLES+3), high for exactly one cycle.
REQ-018 SHALL restart the count from zero on any bounce (sampled returning to stable) before acceptance, so no event results.
REQ-019 SHALL, for simultaneous enter and exit press events, assert enter_pulse first, set an exit-pending flag, and assert exit_pulse on the following cycle; enter_pulse and exit_pulse are never high together.
REQ-020 SHALL clear the exit-pending flag on the cycle it produces exit_pulse.
REQ-021 SHALL, while key_state[2] is 1 or on the clear press event cycle, drop enter/exit press events, clear the exit-pending flag, and keep enter_pulse and exit_pulse low.
REQ-022 SHALL assert clear_pulse regardless of enter/exit activity.
REQ-023 SHALL generate at most one pulse per press regardless of hold duration.

Reset
REQ-024 SHALL, while reset_n = 0, asynchronously force synchronizer flops to released (raw 1), stable levels to 0, counters to 0, and exit-pending to 0.
REQ-025 SHALL, while reset_n = 0, hold enter_pulse, exit_pulse, clear_pulse and key_state at 0.
REQ-026 SHALL emit a pulse after reset release only for a key held pressed through reset, following full debounce from the first post-reset sampling edge.
REQ-027 SHALL discard, with no pulse, any press in progress when reset asserts mid-debounce.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 SHALL cover: pushkey[0] driven 0 cleanly at edge 1 -> key_state[0] = 1 at edge 6, enter_pulse = 1 only in the cycle following edge 7.
REQ-029 SHALL cover: pushkey[1] low 3 cycles, high 1 cycle, then low steadily -> no exit_pulse until 6 edges after the final fall; exactly one exit_pulse results.
REQ-030 SHALL cover: pushkey[0] and pushkey[1] fall on the same edge -> enter_pulse one cycle, exit_pulse the next cycle, never overlapping.
REQ-031 SHALL cover: pushkey[2] held, then pushkey[0] pressed and released while clear is held -> one clear_pulse, zero enter_pulse.
REQ-032 SHALL cover: reset_n pulsed low at debounce counter = 2 of an enter press, key released before reset_n returns high -> no enter_pulse, all outputs 0.
REQ-033 SHALL cover: pushkey[0] held 100 cycles, then released -> exactly one enter_pulse and key_state[0] returning to 0 six edges after release.
